// File: rtl/shift_chain_scrubber.sv
// shift_chain_scrubber: drives a known pattern through a shift chain and counts SEU mismatches per window.
// Define SHIFT_SCRUB_LFSR_EN to use an 8-bit LFSR pattern with a reference delay line instead of alternating bits.
module shift_chain_scrubber #(
  parameter int CHAIN_DEPTH   = 17,
  parameter int WINDOW_CYCLES = 1024,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             clear_total,
  input  logic             chain_q,
  output logic             chain_d,
  output logic             busy,
  output logic             mismatch,
  output logic             win_valid,
  output logic [CNT_W-1:0] win_errs,
  output logic [CNT_W-1:0] total_errs
);
  localparam int MX = CHAIN_DEPTH > WINDOW_CYCLES ? CHAIN_DEPTH : WINDOW_CYCLES;
  localparam int CW = $clog2(MX + 1);
  localparam logic [CNT_W:0] SAT = {1'b0, {CNT_W{1'b1}}};
  typedef enum logic [1:0] {IDLE, PRIME, CHECK} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [CNT_W-1:0] acc, win_new, tot_new;
  logic [CNT_W:0] win_sum, tot_sum;
  logic exp_bit, pat_next, miss, last, prime_end, stop;
`ifdef SHIFT_SCRUB_LFSR_EN
  logic [7:0] lfsr, lfsr_src;
  logic [CHAIN_DEPTH-1:0] ref_dl;
  // IDLE keeps the LFSR primed so the step after the seed is ready on entering PRIME
  assign lfsr_src = state == IDLE ? 8'h01 : lfsr;
  assign exp_bit  = ref_dl[CHAIN_DEPTH-1];
  assign pat_next = lfsr[0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      lfsr   <= 8'h01;
      ref_dl <= '0;
    end else begin
      lfsr   <= {lfsr_src[6:0], lfsr_src[7] ^ lfsr_src[5] ^ lfsr_src[4] ^ lfsr_src[3]};
      ref_dl <= (ref_dl << 1) | CHAIN_DEPTH'(chain_d);
    end
`else
  localparam logic ODD = 1'(CHAIN_DEPTH % 2);
  assign exp_bit  = chain_d ^ ODD;
  assign pat_next = ~chain_d;
`endif
  always_comb begin
    miss      = state == CHECK && chain_q != exp_bit;
    last      = state == CHECK && cnt == CW'(WINDOW_CYCLES - 1);
    prime_end = cnt == CW'(CHAIN_DEPTH - 1);
    stop      = last && !run;
    win_sum   = {1'b0, acc} + {{CNT_W{1'b0}}, miss};
    win_new   = win_sum > SAT ? SAT[CNT_W-1:0] : win_sum[CNT_W-1:0];
    tot_sum   = (clear_total ? '0 : {1'b0, total_errs}) + {1'b0, win_new};
    tot_new   = tot_sum > SAT ? SAT[CNT_W-1:0] : tot_sum[CNT_W-1:0];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      acc        <= '0;
      chain_d    <= 1'b0;
      busy       <= 1'b0;
      mismatch   <= 1'b0;
      win_valid  <= 1'b0;
      win_errs   <= '0;
      total_errs <= '0;
    end else begin
      mismatch   <= miss;
      win_valid  <= last;
      acc        <= last || state != CHECK ? '0 : win_new;
      win_errs   <= last ? win_new : win_errs;
      total_errs <= last ? tot_new : clear_total ? '0 : total_errs;
      case (state)
        IDLE: begin
          state   <= run ? PRIME : IDLE;
          busy    <= run;
          chain_d <= run;
          cnt     <= '0;
        end
        PRIME: begin
          state   <= prime_end ? CHECK : PRIME;
          chain_d <= pat_next;
          cnt     <= prime_end ? '0 : cnt + CW'(1);
        end
        CHECK: begin
          state   <= stop ? IDLE : CHECK;
          busy    <= !stop;
          chain_d <= stop ? 1'b0 : pat_next;
          cnt     <= last ? '0 : cnt + CW'(1);
        end
        default: state <= IDLE;
      endcase
    end
endmodule
